// File: rtl/fetch_queue_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue_if
// Description : Redirect, instruction-fetch and decode signals of fetch_queue.
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_queue_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          redirect_valid;
    logic [31:0]   redirect_pc;
    logic          fetch_enable;
    logic [31:0]   fetch_addr;
    logic [31:0]   instruction;
    logic          instr_valid;
    logic          dec_valid;
    logic [31:0]   dec_instr;
    logic [31:0]   dec_pc;
    logic          dec_ready;
    logic [CW-1:0] queue_count;

    // master is the fetch queue itself; slave is the fetch unit / decode side
    modport master (
        input  redirect_valid, redirect_pc, instruction, instr_valid, dec_ready,
        output fetch_enable, fetch_addr, dec_valid, dec_instr, dec_pc, queue_count
    );

    modport slave (
        output redirect_valid, redirect_pc, instruction, instr_valid, dec_ready,
        input  fetch_enable, fetch_addr, dec_valid, dec_instr, dec_pc, queue_count
    );
endinterface
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue
// Description : Single-outstanding instruction fetcher feeding a FIFO toward
//               decode. Define FETCH_QUEUE_BYPASS_EN for empty-queue bypass.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  wire logic     clk,
    input  wire logic     resetn,
    fetch_queue_if.master bus
);
    localparam int             PW      = $clog2(DEPTH);
    localparam int             CW      = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_DISCARD = 2'd2
    } state_t;

    state_t          state_q;
    logic            fen_q;
    logic [31:0]     addr_q,   addr_d;
    logic [CW-1:0]   count_q,  count_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [31:0]     mem_instr_q [DEPTH];
    logic [31:0]     mem_pc_q    [DEPTH];

    logic            flush;
    logic            accept;
    logic            push;
    logic            pop;
    logic            queue_nonempty;

    assign flush          = bus.redirect_valid;
    assign accept         = (state_q == S_REQ) && bus.instr_valid && !bus.redirect_valid;
    assign queue_nonempty = (count_q != '0);
    assign pop            = queue_nonempty && bus.dec_ready;

`ifdef FETCH_QUEUE_BYPASS_EN
    logic byp_hit;
    // An empty queue forwards the returning word straight to decode; it is
    // only stored if decode does not take it in the same cycle.
    assign byp_hit       = accept && !queue_nonempty;
    assign push          = accept && !(byp_hit && bus.dec_ready);
    assign bus.dec_valid = queue_nonempty || byp_hit;
    assign bus.dec_instr = byp_hit ? bus.instruction : mem_instr_q[rd_ptr_q];
    assign bus.dec_pc    = byp_hit ? addr_q          : mem_pc_q[rd_ptr_q];
`else
    assign push          = accept;
    assign bus.dec_valid = queue_nonempty;
    assign bus.dec_instr = mem_instr_q[rd_ptr_q];
    assign bus.dec_pc    = mem_pc_q[rd_ptr_q];
`endif

    assign bus.fetch_enable = fen_q;
    assign bus.fetch_addr   = addr_q;
    assign bus.queue_count  = count_q;

    // Fetch control; only one request is ever outstanding. Entry to REQ
    // uses the current count, so a pop in the same cycle is not yet credited.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            fen_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!bus.redirect_valid && (count_q < DEPTH_C)) begin
                        state_q <= S_REQ;
                        fen_q   <= 1'b1;
                    end
                end
                S_REQ: begin
                    if (bus.instr_valid) begin
                        state_q <= S_IDLE;
                        fen_q   <= 1'b0;
                    end else if (bus.redirect_valid) begin
                        state_q <= S_DISCARD;
                        fen_q   <= 1'b0;
                    end
                end
                S_DISCARD: begin
                    if (bus.instr_valid) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    fen_q   <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        addr_d   = addr_q;
        if (flush) begin
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            addr_d   = bus.redirect_pc & ~32'd3;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
            if (accept) begin
                addr_d = addr_q + 32'd4;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            addr_q   <= RESET_PC;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_instr_q[i] <= '0;
                mem_pc_q[i]    <= '0;
            end
        end else begin
            addr_q   <= addr_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            if (push) begin
                mem_instr_q[wr_ptr_q] <= bus.instruction;
                mem_pc_q[wr_ptr_q]    <= addr_q;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_queue
// Description : Directed and randomized bench for fetch_queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_queue;
    localparam int DEPTH = 4;
`ifdef FETCH_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } ent_t;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    fetch_queue_if #(.DEPTH(DEPTH)) bus ();

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic idle_inputs();
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.instruction    = 32'h0;
        bus.instr_valid    = 1'b0;
        bus.dec_ready      = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic wait_fe(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (bus.fetch_enable) seen = 1'b1;
            else @(negedge clk);
        end
    endtask

    task automatic serve(input logic [31:0] word, input int lat);
        repeat (lat) @(negedge clk);
        bus.instr_valid = 1'b1;
        bus.instruction = word;
        @(negedge clk);
        bus.instr_valid = 1'b0;
    endtask

    task automatic test_reset();
        bit seen;
        idle_inputs();
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (bus.fetch_enable !== 1'b0) begin failures++; $display("FAIL rst_fetch_enable got=%b exp=0", bus.fetch_enable); end
        checks++; if (bus.fetch_addr !== 32'h0) begin failures++; $display("FAIL rst_fetch_addr got=%h exp=0", bus.fetch_addr); end
        checks++; if (bus.dec_valid !== 1'b0) begin failures++; $display("FAIL rst_dec_valid got=%b exp=0", bus.dec_valid); end
        checks++; if (bus.queue_count !== 3'd0) begin failures++; $display("FAIL rst_queue_count got=%0d exp=0", bus.queue_count); end
        checks++; if ({bus.dec_instr, bus.dec_pc} !== 64'h0) begin failures++; $display("FAIL rst_dec_data got=%h/%h exp=0/0", bus.dec_instr, bus.dec_pc); end
        resetn = 1'b1;
        @(negedge clk); #1;
        checks++; if (bus.fetch_enable !== 1'b1) begin failures++; $display("FAIL rst_first_fetch got=%b exp=1", bus.fetch_enable); end
        // reset in the middle of an outstanding request
        resetn = 1'b0;
        #1;
        checks++; if (bus.fetch_enable !== 1'b0) begin failures++; $display("FAIL rst_mid_fetch_enable got=%b exp=0", bus.fetch_enable); end
        @(negedge clk);
        resetn = 1'b1;
        wait_fe(seen);
        checks++; if (!seen) begin failures++; $display("FAIL rst_mid_refetch got=timeout exp=fetch_enable"); end
        serve(32'h1234_5678, 0);
        #1;
        checks++; if (bus.queue_count !== 3'd1) begin failures++; $display("FAIL rst_mid_not_discarded got=%0d exp=1", bus.queue_count); end
        checks++; if (bus.dec_instr !== 32'h1234_5678) begin failures++; $display("FAIL rst_mid_word got=%h exp=12345678", bus.dec_instr); end
    endtask

    task automatic test_basic();
        bit seen;
        do_reset();
        bus.dec_ready = 1'b1;
        wait_fe(seen);
        checks++; if (!seen) begin failures++; $display("FAIL basic_fetch got=timeout exp=fetch_enable"); end
        repeat (3) @(negedge clk);
        bus.instr_valid = 1'b1;
        bus.instruction = 32'hDEAD_BEEF;
        #1;
`ifdef FETCH_QUEUE_BYPASS_EN
        checks++; if (bus.dec_valid !== 1'b1) begin failures++; $display("FAIL byp_dec_valid got=%b exp=1", bus.dec_valid); end
        checks++; if (bus.dec_instr !== 32'hDEAD_BEEF) begin failures++; $display("FAIL byp_dec_instr got=%h exp=deadbeef", bus.dec_instr); end
        checks++; if (bus.dec_pc !== 32'h0) begin failures++; $display("FAIL byp_dec_pc got=%h exp=0", bus.dec_pc); end
`else
        checks++; if (bus.dec_valid !== 1'b0) begin failures++; $display("FAIL basic_early_valid got=%b exp=0", bus.dec_valid); end
`endif
        @(negedge clk);
        bus.instr_valid = 1'b0;
        #1;
`ifdef FETCH_QUEUE_BYPASS_EN
        checks++; if (bus.queue_count !== 3'd0) begin failures++; $display("FAIL byp_no_push got=%0d exp=0", bus.queue_count); end
`else
        checks++; if (bus.dec_valid !== 1'b1) begin failures++; $display("FAIL basic_dec_valid got=%b exp=1", bus.dec_valid); end
        checks++; if (bus.dec_instr !== 32'hDEAD_BEEF) begin failures++; $display("FAIL basic_dec_instr got=%h exp=deadbeef", bus.dec_instr); end
        checks++; if (bus.dec_pc !== 32'h0) begin failures++; $display("FAIL basic_dec_pc got=%h exp=0", bus.dec_pc); end
        checks++; if (bus.queue_count !== 3'd1) begin failures++; $display("FAIL basic_count got=%0d exp=1", bus.queue_count); end
`endif
        checks++; if (bus.fetch_addr !== 32'h4) begin failures++; $display("FAIL basic_next_addr got=%h exp=4", bus.fetch_addr); end
    endtask

    task automatic test_backpressure();
        bit seen;
        int served;
        do_reset();
        served = 0;
        for (int k = 0; k < 6; k++) begin
            wait_fe(seen);
            if (!seen) break;
            serve(32'hA000_0000 + k, 1);
            served++;
        end
        #1;
        checks++; if (served != DEPTH) begin failures++; $display("FAIL bp_served got=%0d exp=%0d", served, DEPTH); end
        checks++; if (bus.queue_count !== 3'(DEPTH)) begin failures++; $display("FAIL bp_count got=%0d exp=%0d", bus.queue_count, DEPTH); end
        checks++; if (bus.fetch_enable !== 1'b0) begin failures++; $display("FAIL bp_fetch_held got=%b exp=0", bus.fetch_enable); end
        bus.dec_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            #1;
            checks++;
            if (bus.dec_valid !== 1'b1 || bus.dec_instr !== 32'hA000_0000 + i || bus.dec_pc !== 32'(4 * i)) begin
                failures++;
                $display("FAIL bp_drain%0d got=%b/%h/%h exp=1/%h/%h", i, bus.dec_valid, bus.dec_instr, bus.dec_pc, 32'hA000_0000 + i, 4 * i);
            end
            @(negedge clk);
        end
        bus.dec_ready = 1'b0;
        #1;
        checks++; if (bus.queue_count !== 3'd0) begin failures++; $display("FAIL bp_empty got=%0d exp=0", bus.queue_count); end
    endtask

    task automatic test_redirect_outstanding();
        bit seen;
        do_reset();
        wait_fe(seen);
        serve(32'h1111_0000, 0);
        wait_fe(seen);
        checks++; if (!seen) begin failures++; $display("FAIL redir_req got=timeout exp=fetch_enable"); end
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_0103;
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        #1;
        checks++; if (bus.queue_count !== 3'd0) begin failures++; $display("FAIL redir_count got=%0d exp=0", bus.queue_count); end
        checks++; if (bus.fetch_enable !== 1'b0) begin failures++; $display("FAIL redir_fe_drop got=%b exp=0", bus.fetch_enable); end
        checks++; if (bus.fetch_addr !== 32'h100) begin failures++; $display("FAIL redir_addr got=%h exp=100", bus.fetch_addr); end
        bus.instr_valid = 1'b1;
        bus.instruction = 32'hBAD0_BAD0;
        #1;
        checks++; if (bus.dec_valid !== 1'b0) begin failures++; $display("FAIL redir_late_visible got=%b exp=0", bus.dec_valid); end
        @(negedge clk);
        bus.instr_valid = 1'b0;
        #1;
        checks++; if (bus.queue_count !== 3'd0) begin failures++; $display("FAIL redir_late_pushed got=%0d exp=0", bus.queue_count); end
        wait_fe(seen);
        checks++; if (!seen || bus.fetch_addr !== 32'h100) begin failures++; $display("FAIL redir_refetch got=%b/%h exp=1/100", seen, bus.fetch_addr); end
    endtask

    task automatic test_redirect_pop();
        bit seen;
        do_reset();
        wait_fe(seen);
        serve(32'h2222_0000, 0);
        wait_fe(seen);
        bus.instr_valid    = 1'b1;
        bus.instruction    = 32'h2222_0004;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_0200;
        bus.dec_ready      = 1'b1;
        @(negedge clk);
        idle_inputs();
        #1;
        checks++; if (bus.queue_count !== 3'd0) begin failures++; $display("FAIL rpop_count got=%0d exp=0", bus.queue_count); end
        checks++; if (bus.dec_valid !== 1'b0) begin failures++; $display("FAIL rpop_dec_valid got=%b exp=0", bus.dec_valid); end
        checks++; if (bus.fetch_addr !== 32'h200) begin failures++; $display("FAIL rpop_addr got=%h exp=200", bus.fetch_addr); end
        checks++; if (bus.fetch_enable !== 1'b0) begin failures++; $display("FAIL rpop_idle got=%b exp=0", bus.fetch_enable); end
        wait_fe(seen);
        checks++; if (!seen || bus.fetch_addr !== 32'h200) begin failures++; $display("FAIL rpop_refetch got=%b/%h exp=1/200", seen, bus.fetch_addr); end
    endtask

    task automatic test_wrap();
        bit seen;
        do_reset();
        wait_fe(seen);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'hFFFF_FFFC;
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        serve(32'hBAD0_0000, 1);
        wait_fe(seen);
        checks++; if (!seen || bus.fetch_addr !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_addr0 got=%b/%h exp=1/fffffffc", seen, bus.fetch_addr); end
        serve(32'h3333_0001, 1);
        wait_fe(seen);
        checks++; if (!seen || bus.fetch_addr !== 32'h0) begin failures++; $display("FAIL wrap_addr1 got=%b/%h exp=1/0", seen, bus.fetch_addr); end
        serve(32'h3333_0002, 2);
        #1;
        checks++; if (bus.queue_count !== 3'd2) begin failures++; $display("FAIL wrap_count got=%0d exp=2", bus.queue_count); end
        bus.dec_ready = 1'b1;
        #1;
        checks++; if (bus.dec_pc !== 32'hFFFF_FFFC || bus.dec_instr !== 32'h3333_0001) begin failures++; $display("FAIL wrap_head0 got=%h/%h exp=fffffffc/33330001", bus.dec_pc, bus.dec_instr); end
        @(negedge clk); #1;
        checks++; if (bus.dec_pc !== 32'h0 || bus.dec_instr !== 32'h3333_0002) begin failures++; $display("FAIL wrap_head1 got=%h/%h exp=0/33330002", bus.dec_pc, bus.dec_instr); end
        bus.dec_ready = 1'b0;
    endtask

    task automatic test_random();
        ent_t        mq[$];
        ent_t        hd;
        logic [31:0] exp_addr, paddr, pword, rpc;
        bit          pending, drop, deliver, redir, ev, consumed;
        int          plat;
        do_reset();
        mq.delete();
        exp_addr = 32'h0;
        pending  = 1'b0;
        drop     = 1'b0;
        paddr    = 32'h0;
        pword    = 32'h0;
        plat     = 0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            @(negedge clk);
            // behavioural fetch unit: latch request, answer after 0..3 cycles
            if (!pending && bus.fetch_enable) begin
                checks++;
                if (bus.fetch_addr !== exp_addr) begin failures++; $display("FAIL rnd_req_addr cyc=%0d got=%h exp=%h", cyc, bus.fetch_addr, exp_addr); end
                pending = 1'b1;
                paddr   = exp_addr;
                pword   = $urandom;
                plat    = $urandom_range(0, 3);
            end
            deliver = 1'b0;
            if (pending) begin
                if (plat == 0) deliver = 1'b1;
                else plat--;
            end
            redir = ($urandom_range(0, 19) == 0);
            rpc   = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15)) : $urandom;
            bus.redirect_valid = redir;
            bus.redirect_pc    = rpc;
            bus.dec_ready      = ($urandom_range(0, 9) < 7);
            bus.instr_valid    = deliver;
            bus.instruction    = deliver ? pword : $urandom;
            #1;
            checks++;
            if (int'(bus.queue_count) != mq.size()) begin failures++; $display("FAIL rnd_count cyc=%0d got=%0d exp=%0d", cyc, bus.queue_count, mq.size()); end
            ev = (mq.size() != 0) || (BYP && deliver && !drop && !redir);
            hd = (mq.size() != 0) ? mq[0] : ent_t'({pword, paddr});
            checks++;
            if (bus.dec_valid !== ev) begin failures++; $display("FAIL rnd_dec_valid cyc=%0d got=%b exp=%b", cyc, bus.dec_valid, ev); end
            if (ev) begin
                checks++;
                if (bus.dec_instr !== hd.instr || bus.dec_pc !== hd.pc) begin failures++; $display("FAIL rnd_head cyc=%0d got=%h/%h exp=%h/%h", cyc, bus.dec_instr, bus.dec_pc, hd.instr, hd.pc); end
            end
            if (bus.fetch_enable && pending) begin
                checks++;
                if (bus.fetch_addr !== paddr) begin failures++; $display("FAIL rnd_addr_stable cyc=%0d got=%h exp=%h", cyc, bus.fetch_addr, paddr); end
            end
            consumed = 1'b0;
            if (ev && bus.dec_ready) begin
                if (mq.size() != 0) void'(mq.pop_front());
                else consumed = 1'b1;
            end
            if (deliver) begin
                if (!drop && !redir) begin
                    if (!consumed) mq.push_back(ent_t'({pword, paddr}));
                    exp_addr = exp_addr + 32'd4;
                end
                pending = 1'b0;
                drop    = 1'b0;
            end
            if (redir) begin
                mq.delete();
                exp_addr = {rpc[31:2], 2'b00};
                if (pending) drop = 1'b1;
            end
        end
        @(negedge clk);
        idle_inputs();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle_inputs();
        test_reset();
        test_basic();
        test_backpressure();
        test_redirect_outstanding();
        test_redirect_pop();
        test_wrap();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of instruction queue entries; power of two, 2..16.
REQ-002 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-003 clk  input  1  single clock; all state on its rising edge.
REQ-004 resetn  input  1  reset, asynchronous assert, active-low.
REQ-005 redirect_valid  input  1  one-cycle pulse: flush the queue and restart fetch at redirect_pc.
REQ-006 redirect_pc  input  32  new fetch address, sampled when redirect_valid=1.
REQ-007 fetch_enable  output  1  fetch request to instruction_fetch_unit, held high until instr_valid.
REQ-008 fetch_addr  output  32  request address, stable while fetch_enable=1.
REQ-009 instruction  input  32  fetched word from instruction_fetch_unit.
REQ-010 instr_valid  input  1  one-cycle pulse: instruction valid for the outstanding request.
REQ-011 dec_valid  output  1  queue head valid toward decode.
REQ-012 dec_instr  output  32  head instruction word.
REQ-013 dec_pc  output  32  address of head instruction.
REQ-014 dec_ready  input  1  decode accepts head; pop when dec_valid&&dec_ready.
REQ-015 queue_count  output  $clog2(DEPTH)+1  occupied entries.

Function
REQ-016 FSM states IDLE, REQ, DISCARD; exactly one fetch outstanding at any time.
REQ-017 IDLE->REQ when queue_count + 0 < DEPTH and redirect_valid=0; fetch_enable=1 only in REQ.
REQ-018 REQ->IDLE on instr_valid: push {instruction, fetch_addr}, fetch_addr += 4 (32-bit wrap, 0xFFFF_FFFC -> 0x0000_0000).
REQ-019 Push SHALL never overflow: a request is issued only when a free slot exists counting pops of the same cycle as not yet freed.
REQ-020 Simultaneous push and pop: queue_count unchanged; entry ordering FIFO.
REQ-021 Redirect in IDLE: queue cleared, fetch_addr <= {redirect_pc[31:2],2'b00}, stay IDLE for that cycle.
REQ-022 Redirect in REQ without instr_valid: queue cleared, fetch_addr updated, fetch_enable drops next cycle, go DISCARD.
REQ-023 Redirect in REQ with simultaneous instr_valid: returned word dropped, queue cleared, fetch_addr updated, go IDLE.
REQ-024 DISCARD: fetch_enable=0; next instr_valid dropped without push, go IDLE; further redirects in DISCARD only update fetch_addr.
REQ-025 Redirect coinciding with a pop: flush has priority; queue_count=0 next cycle.
REQ-026 dec_valid = (queue_count != 0); dec_instr/dec_pc = head entry; head stable while dec_valid && !dec_ready.
REQ-027 Minimum latency instr_valid -> dec_valid: 1 cycle (see REQ-033).

Reset
REQ-028 While resetn=0: state IDLE, fetch_enable=0, fetch_addr=RESET_PC, dec_valid=0, queue_count=0, dec_instr=0, dec_pc=0, pointers 0.
REQ-029 Reset mid-request: request abandoned; no discard tracking retained.
REQ-030 First fetch_enable asserts in the first cycle after resetn deasserts.

Configuration
REQ-031 Macro FETCH_QUEUE_BYPASS_EN selects empty-queue bypass.
REQ-032 Undefined: every instruction passes through storage; latency per REQ-027.
REQ-033 Defined: queue empty and instr_valid=1 and no redirect -> dec_valid=1 same cycle with dec_instr=instruction, dec_pc=fetch_addr; if dec_ready=1 no push occurs, else word is pushed.

Verification
REQ-034 Reset, RESET_PC=0, dec_ready=1, fetch unit returns 0xDEADBEEF 3 cycles after fetch_enable -> dec_instr=0xDEADBEEF, dec_pc=0x0, next fetch_addr=0x4.
REQ-035 dec_ready=0, 6 returns with DEPTH=4 -> queue_count saturates at 4, fetch_enable stays 0, no word lost; raise dec_ready -> 4 words in order at PCs 0x0,0x4,0x8,0xC.
REQ-036 Redirect to 0x103 while REQ outstanding -> queue_count=0, late instr_valid dropped, next fetch_addr=0x100.
REQ-037 Redirect same cycle as instr_valid and pop -> word dropped, queue_count=0, fetch_addr=redirect_pc.
REQ-038 Redirect to 0xFFFF_FFFC, two returns -> dec_pc 0xFFFF_FFFC then 0x0000_0000.
REQ-039 With FETCH_QUEUE_BYPASS_EN, empty queue, dec_ready=1 -> dec_valid in instr_valid cycle, queue_count stays 0; without it dec_valid one cycle later.
